// File: rtl/pipe_datapath.sv
// pipe_datapath: two-stage pipelined register-file datapath.
//   Stage D holds the accepted instruction, reads rs/rt and runs the ALU
//   combinationally. Stage E registers the result, which is shown on the
//   outputs and written to the register file at the edge that ends E.
//   Latency 2 edges, throughput 1 instruction per cycle.
//
// Build option:
//   FWD_EN defined   - the E result is forwarded into D on a read-after-write
//                      hazard, so the pipeline never stalls.
//   FWD_EN undefined - interlock: D holds for one cycle, a bubble enters E,
//                      and the instruction reads the written-back value.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   instruction present
//   in_ready   instruction accepted when in_valid & in_ready at a clk edge
//   instr      {opcode[3:0], rd, rs, rt/imm}
//   init_en    accepted instruction is a LOAD (opcode ignored)
//   init_data  LOAD value
//   out_valid  alu_out/out_rd carry a stage-E result this cycle
//   alu_out    stage-E result
//   out_rd     stage-E destination register
//   out_zero   alu_out == 0, qualified by out_valid
module pipe_datapath #(
    parameter  int DATA_W  = 16,
    parameter  int ADDR_W  = 4,
    localparam int INSTR_W = 4 + 3*ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               init_en,
    input  logic [DATA_W-1:0]  init_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_out,
    output logic [ADDR_W-1:0]  out_rd,
    output logic               out_zero
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;

    // Field order matches {instr, init_en, init_data} so D loads in one go.
    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic              ld;
        logic [DATA_W-1:0] ldv;
    } dreq_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [ADDR_W-1:0] rd;
    } eres_t;

    logic              run;       // low until the first edge after reset release
    logic [1:0]        vld_pipe;  // [0] D occupied, [1] E holds a writeback result
    dreq_t             d_q;
    eres_t             e_q;
    logic [DATA_W-1:0] rf [2**ADDR_W];

    logic              use_rs, use_rt, wb_op;
    logic              hit_rs, hit_rt, stall;
    logic [DATA_W-1:0] opa, opb, res;

    // Hazard detection: only E can hold a write not yet in the register file.
    always_comb begin
        use_rs = !d_q.ld && (d_q.op <= OP_ADDI);
        use_rt = !d_q.ld && (d_q.op <= OP_XOR);
        wb_op  =  d_q.ld || (d_q.op <= OP_ADDI);
        hit_rs = vld_pipe[0] && vld_pipe[1] && use_rs && (d_q.rs == e_q.rd);
        hit_rt = vld_pipe[0] && vld_pipe[1] && use_rt && (d_q.rt == e_q.rd);
`ifdef FWD_EN
        stall = 1'b0;
        opa   = hit_rs ? e_q.res : rf[d_q.rs];
        opb   = hit_rt ? e_q.res : rf[d_q.rt];
`else
        stall = hit_rs || hit_rt;
        opa   = rf[d_q.rs];
        opb   = rf[d_q.rt];
`endif
    end

    // ALU; the rt field doubles as the unsigned immediate / shift amount.
    always_comb begin
        res = '0;
        if (d_q.ld) begin
            res = d_q.ldv;
        end else begin
            case (d_q.op)
                OP_ADD:  res = opa + opb;
                OP_SUB:  res = opa - opb;
                OP_AND:  res = opa & opb;
                OP_OR:   res = opa | opb;
                OP_XOR:  res = opa ^ opb;
                OP_SLL:  res = (32'(d_q.rt) >= DATA_W) ? '0 : opa << d_q.rt;
                OP_SRL:  res = (32'(d_q.rt) >= DATA_W) ? '0 : opa >> d_q.rt;
                OP_ADDI: res = opa + DATA_W'(d_q.rt);
                default: res = '0;
            endcase
        end
    end

    assign in_ready = run && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            vld_pipe <= '0;
            d_q      <= '0;
            e_q      <= '0;
        end else begin
            run <= 1'b1;
            // On a stall D keeps its instruction and no new one is taken.
            if (!stall) begin
                vld_pipe[0] <= in_valid && in_ready;
                if (in_valid && in_ready)
                    d_q <= {instr, init_en, init_data};
            end
            // NOP/reserved and stalled cycles enter E as bubbles.
            vld_pipe[1] <= vld_pipe[0] && !stall && wb_op;
            if (vld_pipe[0] && !stall && wb_op) begin
                e_q.res <= res;
                e_q.rd  <= d_q.rd;
            end
        end
    end

    // Writeback at the edge ending E; a same-edge read in D sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                rf[i] <= '0;
        end else if (vld_pipe[1]) begin
            rf[e_q.rd] <= e_q.res;
        end
    end

    assign out_valid = vld_pipe[1];
    assign alu_out   = e_q.res;
    assign out_rd    = e_q.rd;
    assign out_zero  = vld_pipe[1] && (e_q.res == '0);

endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: directed bench for pipe_datapath.
//   Inputs are driven on the falling edge; a monitor logs every out_valid
//   result (value, rd, zero flag, cycle stamp) on the falling edge, and the
//   directed steps pop that log against hand-computed values. Cycle gaps and
//   in_ready drops depend on whether FWD_EN is defined.
module tb_pipe_datapath;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int IW = 4 + 3*AW;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_RSV  = 4'hF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] instr = '0;
    logic          init_en = 1'b0;
    logic [DW-1:0] init_data = '0;
    logic          out_valid;
    logic [DW-1:0] alu_out;
    logic [AW-1:0] out_rd;
    logic          out_zero;

    pipe_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .init_en   (init_en),
        .init_data (init_data),
        .out_valid (out_valid),
        .alu_out   (alu_out),
        .out_rd    (out_rd),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nrdy     = 0;

    typedef struct {
        logic [DW-1:0] v;
        logic [AW-1:0] rd;
        logic          z;
        int            c;
    } rec_t;
    rec_t q[$];

    always @(negedge clk) begin
        cyc++;
        if (out_valid === 1'b1)
            q.push_back('{alu_out, out_rd, out_zero, cyc});
        if (reset && in_ready !== 1'b1)
            nrdy++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction and return on the falling edge after it was taken.
    task automatic send(input logic [3:0] op, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic ld, input logic [DW-1:0] v);
        int n;
        n         = 0;
        instr     = {op, rd, rs, rt};
        init_en   = ld;
        init_data = v;
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        init_en  = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] rd, input logic [DW-1:0] v);
        // Reserved opcode on purpose: a LOAD must ignore its opcode.
        send(OP_RSV, rd, '0, '0, 1'b1, v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input string tag, input logic [DW-1:0] v,
                       input logic [AW-1:0] rd, output int c);
        rec_t r;
        if (q.size() > 0) begin
            r = q.pop_front();
        end else begin
            r.v = 'x; r.rd = 'x; r.z = 1'bx; r.c = -1;
        end
        chk({tag, "_val"},  r.v,  v);
        chk({tag, "_rd"},   r.rd, rd);
        chk({tag, "_zero"}, r.z,  (v == '0));
        c = r.c;
    endtask

    initial begin
        int c0, c1, c2, c3, n0;

        // Reset held low for 3 cycles.
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_alu_out",   alu_out,   0);
            chk("rst_out_rd",    out_rd,    0);
            chk("rst_out_zero",  out_zero,  0);
            chk("rst_in_ready",  in_ready,  0);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  in_ready,  1);
        chk("rel_out_valid", out_valid, 0);

        // ADD on a cleared register file.
        send(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, '0);
        idle(3);
        chk("t1_count", q.size(), 1);
        pop("t1_add", 16'h0000, 4'd3, c0);

        // Back-to-back LOADs then a dependent ADD.
        n0 = nrdy;
        load(4'd1, 16'h0005);
        load(4'd2, 16'h0003);
        send(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, '0);
        idle(4);
        chk("t2_count", q.size(), 3);
        pop("t2_ld1", 16'h0005, 4'd1, c0);
        pop("t2_ld2", 16'h0003, 4'd2, c1);
        pop("t2_add", 16'h0008, 4'd3, c2);
        chk("t2_gap_ld", c1 - c0, 1);
`ifdef FWD_EN
        chk("t2_gap_add",   c2 - c1,   1);
        chk("t2_rdy_drops", nrdy - n0, 0);
`else
        chk("t2_gap_add",   c2 - c1,   2);
        chk("t2_rdy_drops", nrdy - n0, 1);
`endif

        // SUB wrap-around, ADDI wrap to zero through a hazard.
        send(OP_SUB, 4'd4, 4'd2, 4'd1, 1'b0, '0);
        load(4'd6, 16'hFFFF);
        send(OP_ADDI, 4'd7, 4'd6, 4'd1, 1'b0, '0);
        idle(4);
        chk("t3_count", q.size(), 3);
        pop("t3_sub",  16'hFFFE, 4'd4, c0);
        pop("t3_ld6",  16'hFFFF, 4'd6, c0);
        pop("t3_addi", 16'h0000, 4'd7, c0);

        // Shift chain, then a reserved opcode that must write nothing.
        load(4'd1, 16'h8000);
        send(OP_SRL, 4'd5, 4'd1, 4'd15, 1'b0, '0);
        send(OP_SLL, 4'd5, 4'd5, 4'd3,  1'b0, '0);
        send(OP_RSV, 4'd1, 4'd0, 4'd0,  1'b0, '0);
        send(OP_ADD, 4'd8, 4'd1, 4'd5,  1'b0, '0);
        idle(4);
        chk("t4_count", q.size(), 4);
        pop("t4_ld1", 16'h8000, 4'd1, c0);
        pop("t4_srl", 16'h0001, 4'd5, c1);
        pop("t4_sll", 16'h0008, 4'd5, c2);
        pop("t4_add", 16'h8008, 4'd8, c3);
        chk("t4_bubble_gap", c3 - c2, 2);

        // Logic ops, no hazards.
        send(OP_AND, 4'd9,  4'd4, 4'd2, 1'b0, '0);
        send(OP_OR,  4'd10, 4'd1, 4'd2, 1'b0, '0);
        send(OP_XOR, 4'd11, 4'd6, 4'd8, 1'b0, '0);
        idle(4);
        chk("t5_count", q.size(), 3);
        pop("t5_and", 16'h0002, 4'd9,  c0);
        pop("t5_or",  16'h8003, 4'd10, c1);
        pop("t5_xor", 16'h7FF7, 4'd11, c2);
        chk("t5_gap", c2 - c0, 2);

        // Reset pulse with LOAD in E and ADD in D.
        load(4'd12, 16'h1234);
        send(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, '0);
        #1 reset = 1'b0;
        #1;
        chk("t6_out_valid_rst", out_valid, 0);
        chk("t6_alu_out_rst",   alu_out,   0);
        chk("t6_in_ready_rst",  in_ready,  0);
        idle(2);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_count_rst", q.size(), 1);
        pop("t6_ld12", 16'h1234, 4'd12, c0);
        send(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, '0);
        idle(3);
        chk("t6_count", q.size(), 1);
        pop("t6_add", 16'h0000, 4'd3, c0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Parametrised two-stage pipelined successor to the lab single-cycle datapath (decode/register-read/ALU, then writeback).
- Accepts one instruction per cycle through a valid/ready handshake.
- Initial data loads travel down the pipeline as LOAD instructions, so writeback order and forwarding stay consistent.
- Sits between the instruction source/testbench and any result consumer.

Parameters:
DATA_W, 16, datapath and register width in bits
ADDR_W, 4, register address width; register count = 2**ADDR_W; instruction width INSTR_W = 4 + 3*ADDR_W

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  instruction accepted when in_valid & in_ready at clk edge
instr  input  INSTR_W  [top 4]=opcode, next ADDR_W=rd, next=rs, low ADDR_W=rt/imm
init_en  input  1  accepted instruction is a LOAD: result = init_data, opcode ignored
init_data  input  DATA_W  LOAD value
out_valid  output  1  alu_out/out_rd valid this cycle
alu_out  output  DATA_W  result of the instruction in stage E
out_rd  output  ADDR_W  destination register of the stage-E result
out_zero  output  1  alu_out == 0 (qualified by out_valid)

Behaviour:
- Reset low (async):
  - register file cleared to 0; D and E valid flags cleared.
  - out_valid=0, alu_out=0, out_rd=0, out_zero=0.
  - in_ready=0 while reset is low, 1 from the first cycle after release.
  - Asserting reset mid-stream discards all in-flight instructions; no partial writeback.
- Stage D register: holds the accepted instruction, init_en and init_data.
  - Reads rs/rt combinationally.
  - ALU evaluates combinationally in the same cycle.
- Stage E register: latches result, rd and write-enable at the next edge.
- Timing: accepted at edge N -> D cycle N+1 -> E cycle N+2.
  - out_valid=1 and alu_out valid in cycle N+2.
  - Register file written at the edge ending cycle N+2.
  - Latency: 2 edges. Throughput: 1 per cycle.
- Opcodes (all arithmetic modulo 2**DATA_W, no flags other than out_zero):
  - 0 ADD rs+rt
  - 1 SUB rs-rt
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL rs<<imm
  - 6 SRL rs>>imm (logical)
  - 7 ADDI rs+zero-extended imm
  - 8 NOP
  - 9-15 reserved
  - imm is the unsigned rt field. A shift amount >= DATA_W yields 0.
- NOP/reserved (init_en=0): flows as a bubble. No writeback; out_valid=0 in its E cycle.
- LOAD (init_en=1): result = init_data, written to rd. No source operands.
- Source usage:
  - ADD..XOR use rs and rt.
  - SLL/SRL/ADDI use rs only.
  - LOAD/NOP use none.
- Hazard: D reads a source equal to E.rd while E is valid with write-enable set. (Writes older than E are already in the register file.)
  - Handled per the optional feature below.
- Same-edge write and read of one register: the register file is write-then-read only via forwarding; a raw read returns the old value.
- D is empty when no instruction was accepted. An empty stage produces no write and no out_valid.

Optional Feature:
- Macro FWD_EN defined: the E result is forwarded to the D operand on a hazard.
  - No stall; in_ready stays 1 outside reset.
- FWD_EN undefined: interlock.
  - On a hazard, D holds and in_ready=0 for exactly 1 cycle.
  - A bubble enters E (out_valid=0 in the following cycle).
  - The instruction proceeds the next cycle reading the written-back value.
  - Results are identical to the forwarding build; only timing differs.

Test Plan:
1. Hold reset low 3 cycles, release -> out_valid=0, alu_out=0 throughout reset, in_ready=1 the cycle after release. Then ADD r3=r1+r2 -> alu_out=0x0000, out_zero=1.
2. FWD_EN, back-to-back LOAD r1=0x0005, LOAD r2=0x0003, ADD r3=r1+r2 -> out_valid on 3 consecutive cycles with 0x0005, 0x0003, 0x0008; in_ready never drops.
3. After test 2: SUB r4=r2-r1 -> 0xFFFE. LOAD r6=0xFFFF then ADDI r7=r6+1 -> 0x0000, out_zero=1.
4. LOAD r1=0x8000. Then:
   - SRL r5=r1>>15 -> 0x0001
   - SLL r5=r5<<3 -> 0x0008 (forwarded)
   - instr with opcode 0xF -> one cycle out_valid=0, no register changed
5. FWD_EN undefined, repeat test 2 -> in_ready=0 for one cycle before ADD enters; one out_valid gap; ADD result still 0x0008.
6. Reset pulsed low while ADD is in D -> out_valid=0 immediately; after release, ADD r3=r1+r2 -> 0x0000 (registers cleared).
